// File: rtl/mem_rd_engine.sv
// Burst read engine for a registered-read RAM: issues one read per cycle under
// FIFO credit and returns data in order. `MEMRD_RANGE_CHK_EN` adds a start-address check.
module mem_rd_engine #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int LENBIT  = 4,
    parameter int RDLAT   = 2,
    parameter int OBUF    = 4
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic [ADDRBIT-1:0] req_addr,
    input  logic [LENBIT-1:0]  req_len,
    output logic [ADDRBIT-1:0] ra,
    output logic               re,
    input  logic [WIDTH-1:0]   do_i,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_last,
    output logic               busy,
    output logic               err
);

    localparam int PTRW = (OBUF > 1) ? $clog2(OBUF) : 1;
    localparam int CNTW = $clog2(OBUF + 1);
    localparam int CRW  = $clog2(2 * OBUF + 2);
    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);
    localparam logic [PTRW-1:0]    LAST_PTR  = PTRW'(OBUF - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [ADDRBIT-1:0] addr_q, addr_d;
    logic [LENBIT-1:0]  cnt_q, cnt_d;
    logic [ADDRBIT-1:0] ra_q, ra_d;
    logic               re_q, re_d;
    logic               tag_q, tag_d;
    logic [RDLAT-1:0]   pvld_q, plast_q;
    logic [CNTW-1:0]    inflight_q, occ_q;
    logic [PTRW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH:0]     mem_q [OBUF];
    logic               issue, push, push_last, pop, has_credit, range_bad;
    logic [CRW-1:0]     used, limit;

    assign push      = pvld_q[RDLAT-1];
    assign push_last = plast_q[RDLAT-1];
    assign rsp_vld   = (occ_q != '0);
    assign pop       = rsp_vld & rsp_rdy;
    assign rsp_data  = rsp_vld ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign rsp_last  = rsp_vld & mem_q[rd_ptr_q][WIDTH];
    assign ra        = ra_q;
    assign re        = re_q;
    assign req_rdy   = rst_ & (state_q == IDLE);
    assign busy      = (state_q != IDLE) | (inflight_q != '0) | rsp_vld;

    // A pop on this edge frees a slot for a read issued on the same edge,
    // which keeps one word per cycle flowing when the consumer never stalls.
    assign used       = CRW'(occ_q) + CRW'(inflight_q);
    assign limit      = CRW'(OBUF) + CRW'(pop);
    assign has_credit = (used < limit);

`ifdef MEMRD_RANGE_CHK_EN
    localparam logic [ADDRBIT:0] DEPTH_W = (ADDRBIT+1)'(DEPTH);
    logic err_q;
    assign range_bad = ({1'b0, req_addr} >= DEPTH_W);
    assign err       = err_q;
    always_ff @(posedge clk) begin
        if (!rst_) err_q <= 1'b0;
        else       err_q <= (state_q == IDLE) & req_vld & range_bad;
    end
`else
    assign range_bad = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ra_d    = ra_q;
        re_d    = 1'b0;
        tag_d   = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld && !range_bad) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (has_credit) begin
                    issue  = 1'b1;
                    ra_d   = addr_q;
                    re_d   = 1'b1;
                    tag_d  = (cnt_q == '0);
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            ra_q       <= '0;
            re_q       <= 1'b0;
            tag_q      <= 1'b0;
            inflight_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            ra_q       <= ra_d;
            re_q       <= re_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_q + CNTW'(issue) - CNTW'(push);
            occ_q      <= occ_q + CNTW'(push) - CNTW'(pop);
            if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Tag pipeline: stage 0 follows the registered re, the last stage lines up with do_i.
    for (genvar gi = 0; gi < RDLAT; gi++) begin : g_pipe
        always_ff @(posedge clk) begin
            if (!rst_) begin
                pvld_q[gi]  <= 1'b0;
                plast_q[gi] <= 1'b0;
            end else if (gi == 0) begin
                pvld_q[gi]  <= re_q;
                plast_q[gi] <= tag_q;
            end else begin
                pvld_q[gi]  <= pvld_q[(gi == 0) ? 0 : gi-1];
                plast_q[gi] <= plast_q[(gi == 0) ? 0 : gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_last, do_i};
    end

endmodule

// File: tb/tb_mem_rd_engine.sv
// Directed bench for mem_rd_engine with a 2-cycle registered-read RAM model
// preloaded with 0xDA7A0000 | address.
module tb_mem_rd_engine;
    localparam int ADDRBIT = 10;
    localparam int DEPTH   = 512;
    localparam int WIDTH   = 32;
    localparam int LENBIT  = 4;
    localparam int RDLAT   = 2;
    localparam int OBUF    = 4;

    logic               clk, rst_, req_vld, req_rdy, re, rsp_vld, rsp_rdy, rsp_last, busy, err;
    logic [ADDRBIT-1:0] req_addr, ra;
    logic [LENBIT-1:0]  req_len;
    logic [WIDTH-1:0]   do_w, rsp_data, ram_s1;
    logic [31:0]        ram [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outstanding = 0;
    int acc_a, acc_b;
    logic [31:0] ra_log[$];
    logic [31:0] data_log[$];
    logic [31:0] last_log[$];
    int          re_cyc[$];
    logic [31:0] exp_ra [0:4];
    logic [31:0] exp_last [0:4];

    mem_rd_engine #(
        .ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH),
        .LENBIT(LENBIT), .RDLAT(RDLAT), .OBUF(OBUF)
    ) dut (
        .clk(clk), .rst_(rst_), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_addr(req_addr), .req_len(req_len), .ra(ra), .re(re),
        .do_i(do_w), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Non-read cycles return junk so a stray capture is visible on rsp_data.
    always @(posedge clk) begin
        ram_s1 <= re ? ram[ra] : 32'hBAD0_BAD0;
        do_w   <= ram_s1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_) begin
            outstanding = 0;
        end else begin
            if (re) begin
                ra_log.push_back(32'(ra));
                re_cyc.push_back(cyc);
                outstanding++;
            end
            if (rsp_vld && rsp_rdy) begin
                data_log.push_back(rsp_data);
                last_log.push_back(32'(rsp_last));
                outstanding--;
            end
            check("no_overflow", 32'(outstanding <= OBUF), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ra_log.delete();
        data_log.delete();
        last_log.delete();
        re_cyc.delete();
    endtask

    task automatic send(input logic [ADDRBIT-1:0] a, input logic [LENBIT-1:0] l, output int acc);
        req_addr = a;
        req_len  = l;
        req_vld  = 1'b1;
        acc      = -1;
        for (int i = 0; i < 64; i++) begin
            if (req_rdy) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        req_vld = 1'b0;
        check("accept_in_time", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_in_time", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hDA7A_0000 | 32'(i);
        rst_ = 1'b0; req_vld = 1'b0; req_addr = '0; req_len = '0; rsp_rdy = 1'b1;
        repeat (3) tick();

        check("rst_re", 32'(re), 32'd0);
        check("rst_ra", 32'(ra), 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_last", 32'(rsp_last), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req_rdy_low", 32'(req_rdy), 32'd0);
        rst_ = 1'b1;
        #1;
        check("idle_req_rdy", 32'(req_rdy), 32'd1);

        // Single word: cycle-by-cycle latency.
        clear_logs();
        req_addr = 10'h010; req_len = 4'd0; req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        check("t1_c0_re", 32'(re), 32'd0);
        tick();
        check("t1_c1_re", 32'(re), 32'd1);
        check("t1_c1_ra", 32'(ra), 32'h010);
        tick();
        check("t1_c2_re", 32'(re), 32'd0);
        tick();
        check("t1_c3_rsp_vld", 32'(rsp_vld), 32'd0);
        tick();
        check("t1_c4_rsp_vld", 32'(rsp_vld), 32'd1);
        check("t1_c4_rsp_last", 32'(rsp_last), 32'd1);
        check("t1_c4_rsp_data", rsp_data, 32'hDA7A_0010);
        check("t1_c4_busy", 32'(busy), 32'd1);
        tick();
        check("t1_c5_rsp_vld", 32'(rsp_vld), 32'd0);
        check("t1_c5_busy", 32'(busy), 32'd0);

        // Wrap from DEPTH-1 to 0 inside a burst.
        clear_logs();
        exp_ra[0] = 32'h1FE; exp_ra[1] = 32'h1FF; exp_ra[2] = 32'h000; exp_ra[3] = 32'h001;
        send(10'h1FE, 4'd3, acc_a);
        wait_idle(40);
        check("t2_issue_count", 32'(ra_log.size()), 32'd4);
        check("t2_rsp_count", 32'(data_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_ra", ra_log[i], exp_ra[i]);
            check("t2_re_cycle", 32'(re_cyc[i]), 32'(acc_a + 1 + i));
            check("t2_data", data_log[i], 32'hDA7A_0000 | exp_ra[i]);
            check("t2_last", last_log[i], 32'(i == 3));
        end

        // Backpressure: credit limits issue to OBUF words.
        clear_logs();
        rsp_rdy = 1'b0;
        send(10'h040, 4'd15, acc_a);
        repeat (12) tick();
        check("t3_issued_under_bp", 32'(ra_log.size()), 32'd4);
        check("t3_re_stalled", 32'(re), 32'd0);
        check("t3_rsp_vld_held", 32'(rsp_vld), 32'd1);
        check("t3_head_data", rsp_data, 32'hDA7A_0040);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_none_popped", 32'(data_log.size()), 32'd0);
        rsp_rdy = 1'b1;
        wait_idle(80);
        check("t3_issue_count", 32'(ra_log.size()), 32'd16);
        check("t3_rsp_count", 32'(data_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("t3_ra", ra_log[i], 32'h040 + 32'(i));
            check("t3_data", data_log[i], 32'hDA7A_0040 + 32'(i));
            check("t3_last", last_log[i], 32'(i == 15));
        end

        // Back-to-back commands.
        clear_logs();
        exp_ra[0] = 32'h020; exp_ra[1] = 32'h021; exp_ra[2] = 32'h100; exp_ra[3] = 32'h101; exp_ra[4] = 32'h102;
        exp_last[0] = 0; exp_last[1] = 1; exp_last[2] = 0; exp_last[3] = 0; exp_last[4] = 1;
        send(10'h020, 4'd1, acc_a);
        send(10'h100, 4'd2, acc_b);
        check("t4_b_accept_cycle", 32'(acc_b), 32'(acc_a + 3));
        wait_idle(40);
        check("t4_rsp_count", 32'(data_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t4_ra", ra_log[i], exp_ra[i]);
            check("t4_data", data_log[i], 32'hDA7A_0000 | exp_ra[i]);
            check("t4_last", last_log[i], exp_last[i]);
        end

        // Reset in the middle of a burst.
        clear_logs();
        send(10'h080, 4'd15, acc_a);
        repeat (5) tick();
        rst_ = 1'b0;
        #1;
        check("t5_req_rdy_in_rst", 32'(req_rdy), 32'd0);
        tick();
        rst_ = 1'b1;
        #1;
        check("t5_rsp_vld", 32'(rsp_vld), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_req_rdy", 32'(req_rdy), 32'd1);
        check("t5_rsp_data", rsp_data, 32'd0);
        check("t5_re", 32'(re), 32'd0);
        clear_logs();
        repeat (8) tick();
        check("t5_no_stale_rsp", 32'(data_log.size()), 32'd0);
        check("t5_no_reads", 32'(ra_log.size()), 32'd0);
        check("t5_rsp_vld_after", 32'(rsp_vld), 32'd0);

`ifdef MEMRD_RANGE_CHK_EN
        clear_logs();
        send(10'h200, 4'd3, acc_a);
        check("t6_err_pulse", 32'(err), 32'd1);
        check("t6_stays_idle", 32'(req_rdy), 32'd1);
        check("t6_re", 32'(re), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        tick();
        check("t6_err_clear", 32'(err), 32'd0);
        repeat (6) tick();
        check("t6_no_reads", 32'(ra_log.size()), 32'd0);
        check("t6_no_rsp", 32'(data_log.size()), 32'd0);
`else
        clear_logs();
        send(10'h200, 4'd0, acc_a);
        check("t6_err_tied", 32'(err), 32'd0);
        wait_idle(40);
        check("t6_issue_count", 32'(ra_log.size()), 32'd1);
        check("t6_ra", ra_log[0], 32'h200);
        check("t6_data", data_log[0], 32'hDA7A_0200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_rd_engine.md
Name: mem_rd_engine

Overview:
- Read-side client for the team's registered read/write-port RAM wrapper; the wrapper's write side is driven elsewhere.
- Accepts burst read commands (start address, length) over a valid/ready handshake and issues one RAM read per cycle on ra/re.
- Realigns returned RAM data using a fixed read latency and buffers it in a small output FIFO.
- Presents data downstream over valid/ready with a last-word marker. Credit-based issue guarantees the output FIFO never overflows under backpressure.

Parameters:
ADDRBIT, 9, RAM address width
DEPTH, 512, RAM word count; need not be a power of two
WIDTH, 32, data width
LENBIT, 4, burst length field width; burst = req_len+1 words (1..16)
RDLAT, 2, cycles from ra/re launch to valid data on do
OBUF, 4, output FIFO depth; must be >= RDLAT+2

Ports:
clk  in  1  single clock for all logic and the RAM read port
rst_  in  1  synchronous, active-low reset
req_vld  in  1  command valid
req_rdy  out  1  command ready
req_addr  in  ADDRBIT  burst start address
req_len  in  LENBIT  burst length minus one
ra  out  ADDRBIT  RAM read address, registered
re  out  1  RAM read enable, registered
do  in  WIDTH  RAM read data, valid RDLAT cycles after re
rsp_vld  out  1  response valid
rsp_rdy  in  1  response ready
rsp_data  out  WIDTH  response word
rsp_last  out  1  marks final word of a burst
busy  out  1  command active, reads in flight, or FIFO non-empty
err  out  1  range-error pulse (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). Reset rst_ is synchronous and active-low. All state is cleared on the clk edge with rst_=0.
- Reset values: state=IDLE, ra=0, re=0, req_rdy=0 while rst_=0, rsp_vld=0, rsp_last=0, rsp_data=0, busy=0, err=0, FIFO empty, in-flight count=0.
- FSM states:
  - IDLE: req_rdy=1. On req_vld&req_rdy, latch addr and remaining count=req_len, then go to RUN.
  - RUN: req_rdy=0. Each cycle with credit>0, issue one read: ra<=addr, re<=1, in-flight tag<=(count==0). Then addr<=(addr==DEPTH-1)?0:addr+1 and count decrements. After issuing the last word, go to IDLE. A new command may be accepted the following cycle while earlier reads are still returning.
- Issue gating: credit = OBUF - fifo_occupancy - inflight. With credit=0, re=0 and ra holds its last value. re is high only on issue cycles.
- Return path:
  - A shift pipeline of depth RDLAT carries {valid, last} alongside each read.
  - When its valid emerges, do is written into the FIFO together with the last tag.
  - The FIFO is first-word-fallthrough: rsp_vld rises the cycle after the write.
  - Pop on rsp_vld&rsp_rdy. Simultaneous push and pop leave occupancy unchanged.
  - The FIFO cannot overflow; the bench asserts this.
- Latency: command accepted at cycle 0 -> re=1 at cycle 1 -> do sampled at cycle 1+RDLAT -> rsp_vld at cycle 2+RDLAT (4 with defaults). Full throughput is one word per cycle with rsp_rdy held at 1.
- Ordering: responses return strictly in issue order. rsp_last is asserted exactly once per burst.
- Address wrap: address DEPTH-1 is followed by address 0 within a burst.
- Reset mid-burst: pipeline tags and FIFO contents are discarded. Data arriving on do after reset is ignored.
- busy = (state!=IDLE) | (inflight!=0) | FIFO non-empty.

Optional Feature:
- Macro: MEMRD_RANGE_CHK_EN.
- Defined: a command with req_addr>=DEPTH is accepted but issues no reads and returns no responses. err=1 for exactly one cycle, the cycle after acceptance. FSM stays in IDLE.
- Undefined: no check. Out-of-range addresses are issued as-is (RAM data undefined) and err is tied to 0.

Test Plan:
- Reset, then single command addr=0x010, len=0, rsp_rdy=1 -> re=1 at cycle 1 with ra=0x010; rsp_vld=1 at cycle 4 with rsp_last=1 and data equal to the RAM preload at 0x010.
- Burst addr=0x1FE, len=3, DEPTH=512 -> ra sequence 0x1FE,0x1FF,0x000,0x001 on consecutive cycles; 4 responses in order, rsp_last on the 4th only.
- Burst len=15 with rsp_rdy=0 -> exactly OBUF=4 reads issued, then re=0 and FIFO full. Release rsp_rdy -> remaining 12 words delivered with no loss or duplication; FIFO never overflows.
- Back-to-back commands A (addr 0x020, len 1) and B (addr 0x100, len 2) -> B accepted the cycle after A's last issue; 5 responses in A-then-B order with rsp_last on words 2 and 5.
- rst_=0 asserted mid-burst for 1 cycle -> next cycle rsp_vld=0, busy=0, req_rdy=1; stale do data never appears on rsp_data.
- With MEMRD_RANGE_CHK_EN defined: command addr=0x200 (DEPTH=512) -> err pulses for 1 cycle, re stays 0, no rsp_vld.
